// File: rtl/dispatch_controller_pkg.sv
// Shared definitions for the dispatch stage: FSM states, opcode codes (same numbering as the Decoder)
// and the instruction-class helpers used to pick the target queue and the live operands.
package dispatch_controller_pkg;

    typedef enum logic [1:0] {
        S_ASK  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } dp_state_e;

    localparam logic [6:0] OP_ILLEGAL = 7'd0;
    localparam logic [6:0] OP_JALR    = 7'd4;
    localparam logic [6:0] OP_BEQ     = 7'd5;
    localparam logic [6:0] OP_BGEU    = 7'd10;
    localparam logic [6:0] OP_LB      = 7'd11;
    localparam logic [6:0] OP_LHU     = 7'd15;
    localparam logic [6:0] OP_SB      = 7'd16;
    localparam logic [6:0] OP_SW      = 7'd18;
    localparam logic [6:0] OP_ADDI    = 7'd19;
    localparam logic [6:0] OP_SRAI    = 7'd27;
    localparam logic [6:0] OP_ADD     = 7'd28;
    localparam logic [6:0] OP_AND     = 7'd37;

    function automatic logic is_branch(input logic [6:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_alu_imm(input logic [6:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

    function automatic logic is_alu_reg(input logic [6:0] op);
        return (op >= OP_ADD) && (op <= OP_AND);
    endfunction

    // lui/auipc/jal and any code outside 1..37 read no register.
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_JALR) || is_branch(op) || is_load(op) || is_store(op)
               || is_alu_imm(op) || is_alu_reg(op);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return is_branch(op) || is_store(op) || is_alu_reg(op);
    endfunction

endpackage

// File: rtl/dispatch_controller_operand_resolve.sv
// Resolves one source operand from the register-file answer, bypassing a same-cycle CDB broadcast.
module dispatch_controller_operand_resolve #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic                 used,
    input  logic [REG_WIDTH-1:0] idx,
    input  logic [ROB_WIDTH:0]   rf_q,
    input  logic [31:0]          rf_v,
    input  logic                 cdb_en,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_val,
    output logic [ROB_WIDTH:0]   q,
    output logic [31:0]          v
);

    // x0 and unused operands are always ready with value zero.
    always_comb begin
        q = '0;
        v = 32'd0;
        if (!used || (idx == '0)) begin
            q = '0;
            v = 32'd0;
        end else if (rf_q[ROB_WIDTH] && cdb_en && (rf_q[ROB_WIDTH-1:0] == cdb_tag)) begin
            q = '0;
            v = cdb_val;
        end else begin
            q = rf_q;
            v = rf_v;
        end
    end

endmodule

// File: rtl/dispatch_controller.sv
// Decode-stage sequencer: requests one instruction, holds it, resolves operands and issues it
// together with a ROB allocation to either the reservation station or the load/store buffer.
module dispatch_controller
    import dispatch_controller_pkg::*;
#(
    parameter int ROB_WIDTH  = 4,
    parameter int REG_WIDTH  = 5,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  DCDP_en,
    input  logic [ADDR_WIDTH-1:0] DCDP_pc,
    input  logic [6:0]            DCDP_opcode,
    input  logic [REG_WIDTH-1:0]  DCDP_rs1,
    input  logic [REG_WIDTH-1:0]  DCDP_rs2,
    input  logic [REG_WIDTH-1:0]  DCDP_rd,
    input  logic [31:0]           DCDP_imm,
    input  logic                  DCDP_predict_result,
    output logic                  DPDC_ask_IF,
    input  logic                  ROB_clear,
    input  logic                  ROBDP_full,
    input  logic [ROB_WIDTH-1:0]  ROBDP_tail,
    input  logic                  RSDP_full,
    input  logic                  LSBDP_full,
    output logic [REG_WIDTH-1:0]  DPRF_rs1,
    output logic [REG_WIDTH-1:0]  DPRF_rs2,
    input  logic [ROB_WIDTH:0]    RFDP_Qj,
    input  logic [ROB_WIDTH:0]    RFDP_Qk,
    input  logic [31:0]           RFDP_Vj,
    input  logic [31:0]           RFDP_Vk,
    input  logic                  CDB_en,
    input  logic [ROB_WIDTH-1:0]  CDB_tag,
    input  logic [31:0]           CDB_val,
    output logic                  DPRF_rename_en,
    output logic                  DPROB_en,
    output logic                  DPRS_en,
    output logic                  DPLSB_en,
    output logic [6:0]            DP_opcode,
    output logic [ADDR_WIDTH-1:0] DP_pc,
    output logic [31:0]           DP_imm,
    output logic [REG_WIDTH-1:0]  DP_rd,
    output logic                  DP_predict_result,
    output logic [ROB_WIDTH:0]    DP_Qj,
    output logic [ROB_WIDTH:0]    DP_Qk,
    output logic [31:0]           DP_Vj,
    output logic [31:0]           DP_Vk,
    output logic [ROB_WIDTH-1:0]  DP_dest
);

    dp_state_e             state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [6:0]            opcode_r;
    logic [REG_WIDTH-1:0]  rs1_r;
    logic [REG_WIDTH-1:0]  rs2_r;
    logic [REG_WIDTH-1:0]  rd_r;
    logic [31:0]           imm_r;
    logic                  pred_r;

    logic active_s;
    logic to_lsb_s;
    logic target_full_s;
    logic issue_s;

    // Sequencer and hold registers; a flush wins over everything, rdy_in low freezes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r  <= S_ASK;
            pc_r     <= '0;
            opcode_r <= 7'd0;
            rs1_r    <= '0;
            rs2_r    <= '0;
            rd_r     <= '0;
            imm_r    <= 32'd0;
            pred_r   <= 1'b0;
        end else if (ROB_clear) begin
            state_r  <= S_ASK;
            pc_r     <= '0;
            opcode_r <= 7'd0;
            rs1_r    <= '0;
            rs2_r    <= '0;
            rd_r     <= '0;
            imm_r    <= 32'd0;
            pred_r   <= 1'b0;
        end else if (rdy_in) begin
            case (state_r)
                S_ASK: state_r <= S_WAIT;
                S_WAIT: begin
                    if (DCDP_en) begin
                        if (DCDP_opcode != OP_ILLEGAL) begin
                            pc_r     <= DCDP_pc;
                            opcode_r <= DCDP_opcode;
                            rs1_r    <= DCDP_rs1;
                            rs2_r    <= DCDP_rs2;
                            rd_r     <= DCDP_rd;
                            imm_r    <= DCDP_imm;
                            pred_r   <= DCDP_predict_result;
                            state_r  <= S_HOLD;
                        end else begin
                            state_r  <= S_ASK;
                        end
                    end
                end
                S_HOLD: begin
                    if (issue_s) begin
                        state_r <= S_ASK;
                    end
                end
                default: state_r <= S_ASK;
            endcase
        end
    end

    // Issue decision: strobes are combinational so consumers capture the payload on this edge.
    always_comb begin
        active_s      = rdy_in && !ROB_clear;
        to_lsb_s      = is_load(opcode_r) || is_store(opcode_r);
        target_full_s = to_lsb_s ? LSBDP_full : RSDP_full;
        issue_s       = active_s && (state_r == S_HOLD) && !ROBDP_full && !target_full_s;
    end

    assign DPDC_ask_IF    = active_s && (state_r == S_ASK);
    assign DPROB_en       = issue_s;
    assign DPRS_en        = issue_s && !to_lsb_s;
    assign DPLSB_en       = issue_s && to_lsb_s;
    // Branches and stores produce no register result; rd==x0 is never renamed.
    assign DPRF_rename_en = issue_s && (rd_r != '0) && !is_branch(opcode_r) && !is_store(opcode_r);

    assign DPRF_rs1          = rs1_r;
    assign DPRF_rs2          = rs2_r;
    assign DP_opcode         = opcode_r;
    assign DP_pc             = pc_r;
    assign DP_imm            = imm_r;
    assign DP_rd             = rd_r;
    assign DP_predict_result = pred_r;
    assign DP_dest           = ROBDP_tail;

    dispatch_controller_operand_resolve #(
        .ROB_WIDTH (ROB_WIDTH),
        .REG_WIDTH (REG_WIDTH)
    ) u_resolve_j (
        .used    (uses_rs1(opcode_r)),
        .idx     (rs1_r),
        .rf_q    (RFDP_Qj),
        .rf_v    (RFDP_Vj),
        .cdb_en  (CDB_en),
        .cdb_tag (CDB_tag),
        .cdb_val (CDB_val),
        .q       (DP_Qj),
        .v       (DP_Vj)
    );

    dispatch_controller_operand_resolve #(
        .ROB_WIDTH (ROB_WIDTH),
        .REG_WIDTH (REG_WIDTH)
    ) u_resolve_k (
        .used    (uses_rs2(opcode_r)),
        .idx     (rs2_r),
        .rf_q    (RFDP_Qk),
        .rf_v    (RFDP_Vk),
        .cdb_en  (CDB_en),
        .cdb_tag (CDB_tag),
        .cdb_val (CDB_val),
        .q       (DP_Qk),
        .v       (DP_Vk)
    );

endmodule

// File: tb/tb_dispatch_controller.sv
// Directed plus randomized bench for dispatch_controller against an instruction-level reference model.
module tb_dispatch_controller;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, DCDP_en, DCDP_predict_result;
    logic [31:0] DCDP_pc, DCDP_imm;
    logic [6:0]  DCDP_opcode;
    logic [4:0]  DCDP_rs1, DCDP_rs2, DCDP_rd;
    logic        DPDC_ask_IF, ROB_clear, ROBDP_full, RSDP_full, LSBDP_full;
    logic [3:0]  ROBDP_tail, CDB_tag, DP_dest;
    logic [4:0]  DPRF_rs1, DPRF_rs2, RFDP_Qj, RFDP_Qk, DP_rd, DP_Qj, DP_Qk;
    logic [31:0] RFDP_Vj, RFDP_Vk, CDB_val, DP_pc, DP_imm, DP_Vj, DP_Vk;
    logic        CDB_en, DPRF_rename_en, DPROB_en, DPRS_en, DPLSB_en, DP_predict_result;
    logic [6:0]  DP_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  cur_op;
    logic [4:0]  cur_rs1, cur_rs2, cur_rd;
    logic [31:0] cur_pc, cur_imm;
    logic        cur_pred;

    dispatch_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .DCDP_en(DCDP_en), .DCDP_pc(DCDP_pc), .DCDP_opcode(DCDP_opcode),
        .DCDP_rs1(DCDP_rs1), .DCDP_rs2(DCDP_rs2), .DCDP_rd(DCDP_rd), .DCDP_imm(DCDP_imm),
        .DCDP_predict_result(DCDP_predict_result), .DPDC_ask_IF(DPDC_ask_IF),
        .ROB_clear(ROB_clear), .ROBDP_full(ROBDP_full), .ROBDP_tail(ROBDP_tail),
        .RSDP_full(RSDP_full), .LSBDP_full(LSBDP_full),
        .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
        .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk), .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk),
        .CDB_en(CDB_en), .CDB_tag(CDB_tag), .CDB_val(CDB_val),
        .DPRF_rename_en(DPRF_rename_en), .DPROB_en(DPROB_en), .DPRS_en(DPRS_en), .DPLSB_en(DPLSB_en),
        .DP_opcode(DP_opcode), .DP_pc(DP_pc), .DP_imm(DP_imm), .DP_rd(DP_rd),
        .DP_predict_result(DP_predict_result), .DP_Qj(DP_Qj), .DP_Qk(DP_Qk),
        .DP_Vj(DP_Vj), .DP_Vk(DP_Vk), .DP_dest(DP_dest)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction classes by mnemonic group: lui/auipc/jal 1-3, jalr 4, branches 5-10,
    // loads 11-15, stores 16-18, I-type ALU 19-27, R-type 28-37.
    function automatic bit m_branch(input int op); return op >= 5 && op <= 10;  endfunction
    function automatic bit m_load(input int op);   return op >= 11 && op <= 15; endfunction
    function automatic bit m_store(input int op);  return op >= 16 && op <= 18; endfunction
    function automatic bit m_ialu(input int op);   return op >= 19 && op <= 27; endfunction
    function automatic bit m_ralu(input int op);   return op >= 28 && op <= 37; endfunction
    function automatic bit m_use1(input int op);
        return op == 4 || m_branch(op) || m_load(op) || m_store(op) || m_ialu(op) || m_ralu(op);
    endfunction
    function automatic bit m_use2(input int op);
        return m_branch(op) || m_store(op) || m_ralu(op);
    endfunction

    // Expected {Q, V} for one operand.
    function automatic logic [36:0] m_operand(input bit used, input logic [4:0] idx,
                                               input logic [4:0] q, input logic [31:0] v);
        if (!used || idx == 5'd0) return 37'd0;
        if (q[4] && CDB_en && q[3:0] == CDB_tag) return {5'd0, CDB_val};
        return {q, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_ask);
        chk({tag, ".ask"},    32'(DPDC_ask_IF),    32'(exp_ask));
        chk({tag, ".rob"},    32'(DPROB_en),       32'd0);
        chk({tag, ".rs"},     32'(DPRS_en),        32'd0);
        chk({tag, ".lsb"},    32'(DPLSB_en),       32'd0);
        chk({tag, ".rename"}, 32'(DPRF_rename_en), 32'd0);
    endtask

    task automatic check_hold(input string tag);
        bit lsb, issue, ren;
        logic [36:0] oj, ok;
        lsb   = m_load(int'(cur_op)) || m_store(int'(cur_op));
        issue = rdy_in && !ROB_clear && !ROBDP_full && !(lsb ? LSBDP_full : RSDP_full);
        ren   = issue && cur_rd != 5'd0 && !m_branch(int'(cur_op)) && !m_store(int'(cur_op));
        oj    = m_operand(m_use1(int'(cur_op)), cur_rs1, RFDP_Qj, RFDP_Vj);
        ok    = m_operand(m_use2(int'(cur_op)), cur_rs2, RFDP_Qk, RFDP_Vk);
        chk({tag, ".ask"},    32'(DPDC_ask_IF),       32'd0);
        chk({tag, ".rob"},    32'(DPROB_en),          32'(issue));
        chk({tag, ".rs"},     32'(DPRS_en),           32'(issue && !lsb));
        chk({tag, ".lsb"},    32'(DPLSB_en),          32'(issue && lsb));
        chk({tag, ".rename"}, 32'(DPRF_rename_en),    32'(ren));
        chk({tag, ".opcode"}, 32'(DP_opcode),         32'(cur_op));
        chk({tag, ".pc"},     DP_pc,                  cur_pc);
        chk({tag, ".imm"},    DP_imm,                 cur_imm);
        chk({tag, ".rd"},     32'(DP_rd),             32'(cur_rd));
        chk({tag, ".pred"},   32'(DP_predict_result), 32'(cur_pred));
        chk({tag, ".rf_rs1"}, 32'(DPRF_rs1),          32'(cur_rs1));
        chk({tag, ".rf_rs2"}, 32'(DPRF_rs2),          32'(cur_rs2));
        chk({tag, ".dest"},   32'(DP_dest),           32'(ROBDP_tail));
        chk({tag, ".Qj"},     32'(DP_Qj),             32'(oj[36:32]));
        chk({tag, ".Vj"},     DP_Vj,                  oj[31:0]);
        chk({tag, ".Qk"},     32'(DP_Qk),             32'(ok[36:32]));
        chk({tag, ".Vk"},     DP_Vk,                  ok[31:0]);
    endtask

    task automatic rand_env();
        RFDP_Qj    = 5'($urandom);
        RFDP_Qk    = 5'($urandom);
        RFDP_Vj    = $urandom;
        RFDP_Vk    = $urandom;
        CDB_en     = 1'($urandom);
        CDB_tag    = ($urandom_range(0, 1) == 1) ? RFDP_Qj[3:0] : 4'($urandom);
        if ($urandom_range(0, 3) == 0) CDB_tag = RFDP_Qk[3:0];
        CDB_val    = $urandom;
        ROBDP_tail = 4'($urandom);
    endtask

    // Drives one instruction from the ASK cycle through issue (or a flush in the issue slot).
    // kind: 0 ROB full, 1 target queue full, 2 rdy_in low, 3 random choice per stall cycle.
    task automatic issue_inst(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input int waits, input int stalls,
                              input int kind, input bit rnd, input bit end_clear);
        bit lsb;
        int k;
        rdy_in = 1'b1; ROB_clear = 1'b0; DCDP_en = 1'b0;
        #1 check_idle("ask", 1'b1);
        tick();
        for (int i = 0; i < waits; i++) begin
            #1 check_idle("wait", 1'b0);
            tick();
        end
        cur_op = op; cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd;
        cur_pc = $urandom; cur_imm = $urandom; cur_pred = 1'($urandom);
        DCDP_en = 1'b1; DCDP_opcode = op; DCDP_rs1 = rs1; DCDP_rs2 = rs2; DCDP_rd = rd;
        DCDP_pc = cur_pc; DCDP_imm = cur_imm; DCDP_predict_result = cur_pred;
        #1 check_idle("latch", 1'b0);
        tick();
        DCDP_en = 1'b0; DCDP_opcode = 7'($urandom_range(1, 37)); DCDP_pc = $urandom;
        DCDP_imm = $urandom; DCDP_rs1 = 5'($urandom); DCDP_rs2 = 5'($urandom); DCDP_rd = 5'($urandom);
        lsb = m_load(int'(op)) || m_store(int'(op));
        for (int s = 0; s < stalls; s++) begin
            if (rnd) rand_env();
            k = (kind == 3) ? int'($urandom_range(0, 2)) : kind;
            rdy_in = 1'b1; ROBDP_full = 1'b0;
            RSDP_full  = rnd ? 1'($urandom) : 1'b0;
            LSBDP_full = rnd ? 1'($urandom) : 1'b0;
            case (k)
                0:       ROBDP_full = 1'b1;
                1:       if (lsb) LSBDP_full = 1'b1; else RSDP_full = 1'b1;
                default: rdy_in = 1'b0;
            endcase
            #1 check_hold("stall");
            tick();
        end
        if (rnd) rand_env();
        rdy_in = 1'b1; ROBDP_full = 1'b0;
        RSDP_full  = (rnd && lsb)  ? 1'($urandom) : 1'b0;
        LSBDP_full = (rnd && !lsb) ? 1'($urandom) : 1'b0;
        ROB_clear  = end_clear;
        #1 check_hold(end_clear ? "clear" : "issue");
        tick();
        ROB_clear = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; DCDP_en = 1'b0; DCDP_pc = 32'd0; DCDP_opcode = 7'd0;
        DCDP_rs1 = 5'd0; DCDP_rs2 = 5'd0; DCDP_rd = 5'd0; DCDP_imm = 32'd0; DCDP_predict_result = 1'b0;
        ROB_clear = 1'b0; ROBDP_full = 1'b0; ROBDP_tail = 4'd0; RSDP_full = 1'b0; LSBDP_full = 1'b0;
        RFDP_Qj = 5'd0; RFDP_Qk = 5'd0; RFDP_Vj = 32'd0; RFDP_Vk = 32'd0;
        CDB_en = 1'b0; CDB_tag = 4'd0; CDB_val = 32'd0;
        cur_op = 7'd0; cur_rs1 = 5'd0; cur_rs2 = 5'd0; cur_rd = 5'd0;
        cur_pc = 32'd0; cur_imm = 32'd0; cur_pred = 1'b0;

        // 1. reset, then ask on the first free cycle only
        repeat (3) tick();
        chk("rst.rob", 32'(DPROB_en), 32'd0);
        chk("rst.rename", 32'(DPRF_rename_en), 32'd0);
        rst_in = 1'b0;
        #1 check_idle("first", 1'b1);

        // 2. addi x1,x2,5 issued the cycle after DCDP_en
        RFDP_Qj = 5'd0; RFDP_Vj = 32'd7; RFDP_Qk = 5'b1_0001; RFDP_Vk = 32'd99; ROBDP_tail = 4'd3;
        issue_inst(7'd19, 5'd2, 5'd9, 5'd1, 1, 0, 0, 1'b0, 1'b0);

        // 3. sw blocked by a full LSB for 4 cycles
        RFDP_Qj = 5'd0; RFDP_Vj = 32'h100; RFDP_Qk = 5'd0; RFDP_Vk = 32'h55; ROBDP_tail = 4'd4;
        issue_inst(7'd18, 5'd3, 5'd4, 5'd6, 0, 4, 1, 1'b0, 1'b0);

        // 4. add with rs1 pending on tag 5, broadcast on the CDB in the issue cycle
        RFDP_Qj = 5'b1_0101; RFDP_Vj = 32'hdead; RFDP_Qk = 5'd0; RFDP_Vk = 32'h9;
        CDB_en = 1'b1; CDB_tag = 4'd5; CDB_val = 32'h1234; ROBDP_tail = 4'd5;
        issue_inst(7'd28, 5'd6, 5'd7, 5'd8, 0, 0, 0, 1'b0, 1'b0);
        CDB_en = 1'b0;

        // 5. flush in the hold state with everything free
        issue_inst(7'd19, 5'd2, 5'd0, 5'd3, 0, 0, 0, 1'b0, 1'b1);

        // 6. lui x0, then add x3,x0,x0 with a pending RF answer
        issue_inst(7'd1, 5'd4, 5'd5, 5'd0, 0, 0, 0, 1'b0, 1'b0);
        RFDP_Qj = 5'b1_1010; RFDP_Qk = 5'b1_0011; RFDP_Vj = 32'h77; RFDP_Vk = 32'h88;
        CDB_en = 1'b1; CDB_tag = 4'd10; CDB_val = 32'h4242;
        issue_inst(7'd28, 5'd0, 5'd0, 5'd3, 0, 0, 0, 1'b0, 1'b0);
        CDB_en = 1'b0;

        // flush in WAIT drops a same-cycle instruction
        #1 check_idle("cw_ask", 1'b1);
        tick();
        DCDP_en = 1'b1; DCDP_opcode = 7'd19; ROB_clear = 1'b1;
        #1 check_idle("cw_flush", 1'b0);
        tick();
        DCDP_en = 1'b0; ROB_clear = 1'b0;
        #1 check_idle("cw_after", 1'b1);

        // rdy_in low freezes ASK; illegal opcode returns to ASK
        rdy_in = 1'b0;
        #1 check_idle("frz_ask", 1'b0);
        tick();
        rdy_in = 1'b1;
        #1 check_idle("frz_rel", 1'b1);
        tick();
        DCDP_en = 1'b1; DCDP_opcode = 7'd0;
        #1 check_idle("ill_en", 1'b0);
        tick();
        DCDP_en = 1'b0;
        #1 check_idle("ill_after", 1'b1);

        // reset while an instruction is held
        tick();
        DCDP_en = 1'b1; DCDP_opcode = 7'd28; DCDP_rd = 5'd9;
        tick();
        DCDP_en = 1'b0; ROBDP_full = 1'b1;
        #1 chk("mh.rob_stall", 32'(DPROB_en), 32'd0);
        rst_in = 1'b1; ROBDP_full = 1'b0;
        #1 check_idle("mh.in_rst", 1'b1);
        tick();
        rst_in = 1'b0;
        #1 check_idle("mh.after", 1'b1);

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = 7'($urandom_range(1, 37));
            rand_env();
            issue_inst(op, 5'($urandom), 5'($urandom), 5'($urandom), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), 3, 1'b1, ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
